morse_letter_checker: RTL and testbench



---
 rtl/morse_letter_checker.sv | 190 +++++++++++++++++++
 tb/tb_morse_letter_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_checker.sv
// rtl/morse_letter_checker.sv - decodes a captured Morse letter and scores it against a generated target
//
// Optional hint logic is built when MORSE_HINT_EN is defined; otherwise hint outputs are tied to 0.
//
// Ports:
//   clock, reset_n                  rising-edge clock, asynchronous active-low reset
//   morse_one..morse_five [1:0]     symbol slots: 00 empty, 01 dot, 10 dash, 11 illegal
//   letter_done                     level, high while a completed letter is presented
//   target_letter [4:0]             current target, 0=A..25=Z
//   decoded_letter [4:0]            last decoded letter, 31 = invalid pattern
//   result_correct / result_wrong   one-cycle verdict pulses
//   result_show                     high for RESULT_HOLD cycles after a verdict
//   score / streak [SCORE_W-1:0]    saturating counters
//   hint_valid, hint_morse [9:0]    target pattern hint, slot one in [9:8]
//   busy                            high whenever the FSM is not in IDLE
module morse_letter_checker #(
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         SCORE_W     = 8,
  parameter int         RESULT_HOLD = 50_000_000,
  parameter int         WRONG_LIMIT = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         morse_one,
  input  logic [1:0]         morse_two,
  input  logic [1:0]         morse_three,
  input  logic [1:0]         morse_four,
  input  logic [1:0]         morse_five,
  input  logic               letter_done,
  output logic [4:0]         target_letter,
  output logic [4:0]         decoded_letter,
  output logic               result_correct,
  output logic               result_wrong,
  output logic               result_show,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak,
  output logic               hint_valid,
  output logic [9:0]         hint_morse,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, DECODE, COMPARE, SHOW, NEXT} state_t;

  localparam int   HOLD_W  = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic SEED_OK = (SEED[4:0] < 5'd26);

  // Slots one..four per letter; slot five is always empty for A-Z.
  // Entries 26..31 are padding so a 5-bit index never leaves the table.
  localparam logic [7:0] MORSE_ROM [32] = '{
    8'b01_10_00_00, 8'b10_01_01_01, 8'b10_01_10_01, 8'b10_01_01_00, // A B C D
    8'b01_00_00_00, 8'b01_01_10_01, 8'b10_10_01_00, 8'b01_01_01_01, // E F G H
    8'b01_01_00_00, 8'b01_10_10_10, 8'b10_01_10_00, 8'b01_10_01_01, // I J K L
    8'b10_10_00_00, 8'b10_01_00_00, 8'b10_10_10_00, 8'b01_10_10_01, // M N O P
    8'b10_10_01_10, 8'b01_10_01_00, 8'b01_01_01_00, 8'b10_00_00_00, // Q R S T
    8'b01_01_10_00, 8'b01_01_01_10, 8'b01_10_10_00, 8'b10_01_01_10, // U V W X
    8'b10_01_10_10, 8'b10_10_01_01,                                 // Y Z
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Every table entry is a well-formed pattern, so gaps, 11 symbols and
  // the all-empty pattern simply miss the table and fall out as 31.
  function automatic logic [4:0] decode_pattern(input logic [9:0] p);
    logic [4:0] r;
    r = 5'd31;
    if (p[1:0] == 2'b00) begin
      for (int i = 0; i < 26; i++) begin
        if (p[9:2] == MORSE_ROM[i]) r = 5'(i);
      end
    end
    return r;
  endfunction

  state_t              state, state_nxt;
  logic [7:0]          lfsr, lfsr_step;
  logic [9:0]          capture;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                letter_done_prev, pending, last_correct;
  logic                start, match, next_ok;

  assign start       = letter_done & ~letter_done_prev;
  assign match       = (decoded_letter == target_letter);
  // An all-zero LFSR would lock up; kick it to 1 so NEXT always terminates.
  assign lfsr_step   = (lfsr == 8'h00) ? 8'h01
                     : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign next_ok     = (lfsr_step[4:0] < 5'd26) && (lfsr_step[4:0] != target_letter);
  assign busy        = (state != IDLE);
  assign result_show = (state == SHOW);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SEED_OK ? IDLE : NEXT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || pending) state_nxt = DECODE;
      DECODE:  state_nxt = COMPARE;
      COMPARE: state_nxt = SHOW;
      SHOW:    if (hold_cnt == '0) state_nxt = last_correct ? NEXT : IDLE;
      NEXT:    if (next_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // When SEED[4:0] is not a letter, target_letter starts out of range so any
  // letter found by the post-reset NEXT pass counts as different.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr             <= SEED;
      target_letter    <= SEED[4:0];
      decoded_letter   <= 5'd31;
      result_correct   <= 1'b0;
      result_wrong     <= 1'b0;
      score            <= '0;
      streak           <= '0;
      capture          <= '0;
      hold_cnt         <= '0;
      letter_done_prev <= 1'b0;
      pending          <= 1'b0;
      last_correct     <= 1'b0;
    end else begin
      letter_done_prev <= letter_done;
      result_correct   <= 1'b0;
      result_wrong     <= 1'b0;
      if (state != IDLE && start) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start || pending) begin
            capture <= {morse_one, morse_two, morse_three, morse_four, morse_five};
            pending <= 1'b0;
          end
        end
        DECODE: decoded_letter <= decode_pattern(capture);
        COMPARE: begin
          hold_cnt     <= HOLD_W'(RESULT_HOLD - 1);
          last_correct <= match;
          if (match) begin
            result_correct <= 1'b1;
            if (score  != '1) score  <= score  + SCORE_W'(1);
            if (streak != '1) streak <= streak + SCORE_W'(1);
          end else begin
            result_wrong <= 1'b1;
            streak       <= '0;
          end
        end
        SHOW: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        NEXT: begin
          lfsr <= lfsr_step;
          if (next_ok) target_letter <= lfsr_step[4:0];
        end
        default: ;
      endcase
    end
  end

`ifdef MORSE_HINT_EN
  localparam int WC_W = (WRONG_LIMIT > 1) ? $clog2(WRONG_LIMIT + 1) : 1;

  logic [WC_W-1:0] wrong_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrong_cnt  <= '0;
      hint_valid <= 1'b0;
      hint_morse <= '0;
    end else if (state == COMPARE) begin
      if (match) begin
        wrong_cnt  <= '0;
        hint_valid <= 1'b0;
        hint_morse <= '0;
      end else if (wrong_cnt != WC_W'(WRONG_LIMIT)) begin
        wrong_cnt <= wrong_cnt + 1'b1;
        if (wrong_cnt == WC_W'(WRONG_LIMIT - 1)) begin
          hint_valid <= 1'b1;
          hint_morse <= {MORSE_ROM[target_letter], 2'b00};
        end
      end
    end else if (state == NEXT && next_ok) begin
      wrong_cnt  <= '0;
      hint_valid <= 1'b0;
      hint_morse <= '0;
    end
  end
`else
  assign hint_valid = 1'b0;
  assign hint_morse = '0;
`endif

endmodule

// File: tb/tb_morse_letter_checker.sv
// tb/tb_morse_letter_checker.sv - directed self-checking bench for morse_letter_checker
module tb_morse_letter_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] morse_one = '0, morse_two = '0, morse_three = '0, morse_four = '0, morse_five = '0;
  logic       letter_done = 1'b0;
  logic [4:0] target_letter, decoded_letter;
  logic       result_correct, result_wrong, result_show, hint_valid, busy;
  logic [1:0] score, streak;
  logic [9:0] hint_morse;

  int checks = 0;
  int failures = 0;
  int n_correct = 0;
  int n_wrong = 0;

  localparam logic [9:0] P_A = 10'b01_10_00_00_00;
  localparam logic [9:0] P_B = 10'b10_01_01_01_00;
  localparam logic [9:0] P_C = 10'b10_01_10_01_00;
  localparam logic [9:0] P_D = 10'b10_01_01_00_00;
  localparam logic [9:0] P_E = 10'b01_00_00_00_00;
  localparam logic [9:0] P_H = 10'b01_01_01_01_00;
  localparam logic [9:0] P_I = 10'b01_01_00_00_00;
  localparam logic [9:0] P_R = 10'b01_10_01_00_00;

  morse_letter_checker #(
    .SEED(8'h00), .SCORE_W(2), .RESULT_HOLD(4), .WRONG_LIMIT(3)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .morse_one(morse_one), .morse_two(morse_two), .morse_three(morse_three),
    .morse_four(morse_four), .morse_five(morse_five), .letter_done(letter_done),
    .target_letter(target_letter), .decoded_letter(decoded_letter),
    .result_correct(result_correct), .result_wrong(result_wrong),
    .result_show(result_show), .score(score), .streak(streak),
    .hint_valid(hint_valid), .hint_morse(hint_morse), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (result_correct) n_correct++;
    if (result_wrong)   n_wrong++;
  end

  task automatic set_slots(input logic [9:0] p);
    {morse_one, morse_two, morse_three, morse_four, morse_five} = p;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 40);
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic submit(input logic [9:0] p, input string name);
    @(negedge clock);
    set_slots(p);
    letter_done = 1'b1;
    @(negedge clock);
    letter_done = 1'b0;
    wait_idle(name);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (target_letter !== 5'd0)  begin failures++; $display("FAIL reset_target: got %0d want 0", target_letter); end
    checks++; if (decoded_letter !== 5'd31) begin failures++; $display("FAIL reset_decoded: got %0d want 31", decoded_letter); end
    checks++; if ({score, streak} !== 4'd0) begin failures++; $display("FAIL reset_counts: got %b want 0000", {score, streak}); end
    checks++; if ({busy, result_show, result_correct, result_wrong, hint_valid} !== 5'd0 || hint_morse !== 10'd0) begin
      failures++; $display("FAIL reset_flags: got %b/%b want 0", {busy, result_show, result_correct, result_wrong, hint_valid}, hint_morse);
    end
  endtask

  task automatic test_correct_latency;
    logic [12:1] rc, rs;
    @(negedge clock);
    set_slots(P_A);
    letter_done = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) letter_done = 1'b0;
      rc[k] = result_correct;
      rs[k] = result_show;
    end
    checks++; if (rc !== 12'b0000_0000_0100) begin failures++; $display("FAIL latency_pulse: got %b want 000000000100", rc); end
    checks++; if (rs !== 12'b0000_0011_1100) begin failures++; $display("FAIL show_window: got %b want 000000111100", rs); end
    checks++; if (decoded_letter !== 5'd0) begin failures++; $display("FAIL latency_decoded: got %0d want 0", decoded_letter); end
    checks++; if (score !== 2'd1 || streak !== 2'd1) begin failures++; $display("FAIL latency_counts: got %0d/%0d want 1/1", score, streak); end
    checks++; if (busy !== 1'b0 || target_letter !== 5'd1) begin failures++; $display("FAIL next_target: got busy=%b target=%0d want 0/1", busy, target_letter); end
  endtask

  task automatic test_wrong;
    int w0;
    w0 = n_wrong;
    submit(P_A, "wrong_idle");
    checks++; if (decoded_letter !== 5'd0) begin failures++; $display("FAIL wrong_decoded: got %0d want 0", decoded_letter); end
    checks++; if (n_wrong - w0 !== 1) begin failures++; $display("FAIL wrong_pulse: got %0d want 1", n_wrong - w0); end
    checks++; if (score !== 2'd1 || streak !== 2'd0 || target_letter !== 5'd1) begin
      failures++; $display("FAIL wrong_state: got score=%0d streak=%0d target=%0d want 1/0/1", score, streak, target_letter);
    end
  endtask

  task automatic test_illegal;
    logic [9:0] pats [3];
    int w0;
    pats = '{10'b01_00_10_00_00, 10'b11_00_00_00_00, 10'b01_01_01_01_01};
    for (int i = 0; i < 3; i++) begin
      w0 = n_wrong;
      submit(pats[i], "illegal_idle");
      checks++; if (decoded_letter !== 5'd31 || n_wrong - w0 !== 1) begin
        failures++; $display("FAIL illegal_%0d: got decoded=%0d wrongs=%0d want 31/1", i, decoded_letter, n_wrong - w0);
      end
    end
    checks++; if (target_letter !== 5'd1 || score !== 2'd1) begin failures++; $display("FAIL illegal_state: got target=%0d score=%0d want 1/1", target_letter, score); end
  endtask

  task automatic test_saturate;
    logic [9:0] pats [4];
    logic [4:0] tgt  [4];
    logic [1:0] sc   [4];
    logic [1:0] st   [4];
    pats = '{P_B, P_C, P_E, P_I};
    tgt  = '{5'd2, 5'd4, 5'd8, 5'd17};
    sc   = '{2'd2, 2'd3, 2'd3, 2'd3};
    st   = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      submit(pats[i], "sat_idle");
      checks++; if (score !== sc[i] || streak !== st[i] || target_letter !== tgt[i]) begin
        failures++;
        $display("FAIL saturate_%0d: got score=%0d streak=%0d target=%0d want %0d/%0d/%0d",
                 i, score, streak, target_letter, sc[i], st[i], tgt[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c0, w0, n;
    c0 = n_correct;
    w0 = n_wrong;
    @(negedge clock);
    set_slots(P_R);
    letter_done = 1'b1;
    @(negedge clock);
    letter_done = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!result_show && n < 10);
    checks++; if (result_show !== 1'b1) begin failures++; $display("FAIL b2b_show: got %b want 1", result_show); end
    set_slots(P_E);
    letter_done = 1'b1;
    @(negedge clock);
    letter_done = 1'b0;
    @(negedge clock);
    letter_done = 1'b1;
    @(negedge clock);
    letter_done = 1'b0;
    repeat (40) @(negedge clock);
    checks++; if (n_correct - c0 !== 1 || n_wrong - w0 !== 1) begin
      failures++; $display("FAIL b2b_verdicts: got correct=%0d wrong=%0d want 1/1", n_correct - c0, n_wrong - w0);
    end
    checks++; if (target_letter !== 5'd3 || decoded_letter !== 5'd4 || streak !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_state: got target=%0d decoded=%0d streak=%0d busy=%b want 3/4/0/0", target_letter, decoded_letter, streak, busy);
    end
  endtask

  task automatic test_hint;
    logic       exp_valid;
    logic [9:0] exp_morse;
`ifdef MORSE_HINT_EN
    exp_valid = 1'b1;
    exp_morse = 10'b10_01_01_00_00;
`else
    exp_valid = 1'b0;
    exp_morse = 10'b0;
`endif
    submit(P_E, "hint_idle");
    checks++; if (hint_valid !== 1'b0) begin failures++; $display("FAIL hint_early: got %b want 0", hint_valid); end
    submit(P_E, "hint_idle");
    checks++; if (hint_valid !== exp_valid || hint_morse !== exp_morse) begin
      failures++; $display("FAIL hint_limit: got %b/%b want %b/%b", hint_valid, hint_morse, exp_valid, exp_morse);
    end
    submit(P_D, "hint_idle");
    checks++; if (hint_valid !== 1'b0 || hint_morse !== 10'd0) begin failures++; $display("FAIL hint_clear: got %b/%b want 0", hint_valid, hint_morse); end
    checks++; if (target_letter !== 5'd7 || score !== 2'd3 || streak !== 2'd1) begin
      failures++; $display("FAIL hint_next: got target=%0d score=%0d streak=%0d want 7/3/1", target_letter, score, streak);
    end
  endtask

  task automatic test_reset_midop;
    int c0, w0;
    @(negedge clock);
    set_slots(P_H);
    letter_done = 1'b1;
    @(negedge clock);
    letter_done = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || target_letter !== 5'd0 || decoded_letter !== 5'd31 || {score, streak} !== 4'd0 || result_show !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: got busy=%b target=%0d decoded=%0d score=%0d streak=%0d", busy, target_letter, decoded_letter, score, streak);
    end
    @(negedge clock);
    reset_n = 1'b1;
    c0 = n_correct;
    w0 = n_wrong;
    repeat (8) @(negedge clock);
    checks++; if (n_correct != c0 || n_wrong != w0 || busy !== 1'b0) begin
      failures++; $display("FAIL midop_quiet: got correct=%0d wrong=%0d busy=%b want 0/0/0", n_correct - c0, n_wrong - w0, busy);
    end
  endtask

  initial begin
    test_reset;
    test_correct_latency;
    test_wrong;
    test_illegal;
    test_saturate;
    test_back_to_back;
    test_hint;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
